clock_pattern_generator: RTL and testbench

CLOCK_PATTERN_GENERATOR -- requirements
Module: clock_pattern_generator

---
 rtl/clock_pattern_generator.sv | 139 +++++++++++++
 tb/tb_clock_pattern_generator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_pattern_generator.sv
// Clock pattern generator: emits a gated CKP/CKN training burst, then a free-running clock pattern.
// Defining CLKGEN_TRACK_EN adds the o_track output, a copy of o_ckp.
module clock_pattern_generator #(
  parameter int WORD_W = 16,
  parameter int ON_UI  = 32,
  parameter int OFF_UI = 16,
  parameter int ITER   = 128
) (
  input  logic                       i_dig_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start_clk_training,
  input  logic                       i_ltsm_in_reset,
  output logic [WORD_W-1:0]          o_ckp,
  output logic [WORD_W-1:0]          o_ckn,
  output logic                       o_done,
  output logic                       o_busy,
`ifdef CLKGEN_TRACK_EN
  output logic [$clog2(ITER+1)-1:0]  o_iter_cnt,
  output logic [WORD_W-1:0]          o_track
`else
  output logic [$clog2(ITER+1)-1:0]  o_iter_cnt
`endif
);

  localparam int PERIOD = ON_UI + OFF_UI;
  localparam int TOTAL  = PERIOD * ITER / WORD_W;
  localparam int SW     = $clog2(PERIOD + WORD_W);
  localparam int IW     = $clog2(ITER + 1);
  localparam int CW     = $clog2(TOTAL + 1);
  localparam int STEP_R = WORD_W % PERIOD;
  localparam int STEP_K = WORD_W / PERIOD;

  typedef enum logic [1:0] {IDLE, TRAIN, NORMAL} state_t;

  state_t            state_reg, state_next;
  logic              start_reg, armed_reg;
  logic              rise, fall;
  logic [SW-1:0]     phase_reg, phase_next, phase_sum, phase_adv;
  logic              wrap;
  logic [CW-1:0]     word_cnt_reg, word_cnt_next;
  logic [IW-1:0]     iter_cnt_reg, iter_cnt_next;
  logic [WORD_W-1:0] ckp_reg, ckp_next, ckn_reg, ckn_next;
  logic [WORD_W-1:0] train_ckp, train_ckn, normal_ckp;
  logic              done_reg, done_next, busy_reg, busy_next;

  // armed_reg blocks a start level held high through reset from looking like an edge
  assign rise = i_start_clk_training & ~start_reg & armed_reg;
  assign fall = ~i_start_clk_training & start_reg;

  assign phase_sum = phase_reg + SW'(STEP_R);
  assign wrap      = phase_sum >= SW'(PERIOD);
  assign phase_adv = wrap ? phase_sum - SW'(PERIOD) : phase_sum;

  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_ui
    logic [SW-1:0] ui_sum, ui_pos;
    assign ui_sum         = phase_reg + SW'(gi);
    assign ui_pos         = ui_sum % SW'(PERIOD);
    assign train_ckp[gi]  = (ui_pos < SW'(ON_UI)) & ~ui_pos[0];
    assign train_ckn[gi]  = (ui_pos < SW'(ON_UI)) & ui_pos[0];
    assign normal_ckp[gi] = ((gi % 2) == 0);
  end

  always_ff @(posedge i_dig_clk) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      start_reg    <= 1'b0;
      armed_reg    <= ~i_start_clk_training;
      phase_reg    <= '0;
      word_cnt_reg <= '0;
      iter_cnt_reg <= '0;
      ckp_reg      <= '0;
      ckn_reg      <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      start_reg    <= i_start_clk_training;
      armed_reg    <= armed_reg | ~i_start_clk_training;
      phase_reg    <= phase_next;
      word_cnt_reg <= word_cnt_next;
      iter_cnt_reg <= iter_cnt_next;
      ckp_reg      <= ckp_next;
      ckn_reg      <= ckn_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise && !i_ltsm_in_reset) state_next = TRAIN;
      TRAIN: begin
        if (i_ltsm_in_reset)                   state_next = IDLE;
        else if (word_cnt_reg == CW'(TOTAL))   state_next = NORMAL;
      end
      NORMAL:  if (i_ltsm_in_reset) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they line up with it after the edge
  always_comb begin
    ckp_next      = '0;
    ckn_next      = '0;
    busy_next     = 1'b0;
    phase_next    = '0;
    word_cnt_next = '0;
    iter_cnt_next = '0;
    done_next     = done_reg & ~fall;
    case (state_next)
      TRAIN: begin
        ckp_next      = train_ckp;
        ckn_next      = train_ckn;
        busy_next     = 1'b1;
        phase_next    = phase_adv;
        word_cnt_next = word_cnt_reg + CW'(1);
        iter_cnt_next = iter_cnt_reg + IW'(STEP_K) + IW'(wrap);
      end
      NORMAL: begin
        ckp_next      = normal_ckp;
        ckn_next      = ~normal_ckp;
        iter_cnt_next = iter_cnt_reg;
        if (state_reg == TRAIN) done_next = 1'b1;
      end
      default: done_next = 1'b0;
    endcase
  end

  assign o_ckp      = ckp_reg;
  assign o_ckn      = ckn_reg;
  assign o_done     = done_reg;
  assign o_busy     = busy_reg;
  assign o_iter_cnt = iter_cnt_reg;
`ifdef CLKGEN_TRACK_EN
  assign o_track    = ckp_reg;
`endif

endmodule

// File: tb/tb_clock_pattern_generator.sv
// Scoreboard bench for clock_pattern_generator: a UI-level reference model queues the expected
// outputs for every cycle, and a monitor pops and compares them after each clock edge.
module tb_clock_pattern_generator;

  localparam int WORD_W = 8;
  localparam int ON_UI  = 6;
  localparam int OFF_UI = 4;
  localparam int ITER   = 4;
  localparam int PERIOD = ON_UI + OFF_UI;
  localparam int TOTAL  = PERIOD * ITER / WORD_W;
  localparam int IW     = $clog2(ITER + 1);
  localparam int M_IDLE = 0, M_TRAIN = 1, M_NORMAL = 2;

  logic              clk = 1'b0;
  logic              rst_n, start, ltsm;
  logic [WORD_W-1:0] ckp, ckn;
  logic              done, busy;
  logic [IW-1:0]     iter_cnt;
`ifdef CLKGEN_TRACK_EN
  logic [WORD_W-1:0] track;
`endif

  always #5 clk = ~clk;

  clock_pattern_generator #(
    .WORD_W(WORD_W), .ON_UI(ON_UI), .OFF_UI(OFF_UI), .ITER(ITER)
  ) dut (
    .i_dig_clk(clk),
    .i_rst_n(rst_n),
    .i_start_clk_training(start),
    .i_ltsm_in_reset(ltsm),
    .o_ckp(ckp),
    .o_ckn(ckn),
    .o_done(done),
    .o_busy(busy),
`ifdef CLKGEN_TRACK_EN
    .o_iter_cnt(iter_cnt),
    .o_track(track)
`else
    .o_iter_cnt(iter_cnt)
`endif
  );

  typedef struct {
    logic [WORD_W-1:0] ckp;
    logic [WORD_W-1:0] ckn;
    logic              done;
    logic              busy;
    logic [IW-1:0]     iter;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycle      = 0;

  // Reference model state: mode, training words emitted so far, done flag, last sampled start level
  int m_mode  = M_IDLE;
  int m_words = 0;
  bit m_done  = 1'b0;
  bit m_prev  = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    int   u, p;
    e.ckp  = '0;
    e.ckn  = '0;
    e.done = m_done;
    e.busy = 1'b0;
    e.iter = '0;
    if (m_mode == M_TRAIN) begin
      e.busy = 1'b1;
      for (int i = 0; i < WORD_W; i++) begin
        u = (m_words - 1) * WORD_W + i;
        p = u % PERIOD;
        if (p < ON_UI) begin
          if (p % 2 == 0) e.ckp[i] = 1'b1;
          else            e.ckn[i] = 1'b1;
        end
      end
      e.iter = IW'(m_words * WORD_W / PERIOD);
    end else if (m_mode == M_NORMAL) begin
      for (int i = 0; i < WORD_W; i++) begin
        e.ckp[i] = (i % 2 == 0);
        e.ckn[i] = (i % 2 != 0);
      end
      e.iter = IW'(ITER);
    end
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model over the coming edge, queue the expected result
  task automatic step(input bit r, input bit s, input bit l);
    bit rise_e, fall_e;
    rst_n = r;
    start = s;
    ltsm  = l;
    if (!r) begin
      m_mode  = M_IDLE;
      m_words = 0;
      m_done  = 1'b0;
    end else begin
      rise_e = s && !m_prev;
      fall_e = !s && m_prev;
      case (m_mode)
        M_IDLE: if (rise_e && !l) begin
          m_mode  = M_TRAIN;
          m_words = 1;
        end
        M_TRAIN: begin
          if (l) begin
            m_mode  = M_IDLE;
            m_words = 0;
          end else if (m_words == TOTAL) begin
            m_mode = M_NORMAL;
            m_done = 1'b1;
          end else begin
            m_words++;
          end
        end
        default: begin
          if (l) begin
            m_mode  = M_IDLE;
            m_words = 0;
            m_done  = 1'b0;
          end else if (fall_e) begin
            m_done = 1'b0;
          end
        end
      endcase
    end
    m_prev = s;
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      cycle++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ckp", 32'(ckp), 32'(e.ckp));
        chk("ckn", 32'(ckn), 32'(e.ckn));
        chk("done", 32'(done), 32'(e.done));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("iter_cnt", 32'(iter_cnt), 32'(e.iter));
`ifdef CLKGEN_TRACK_EN
        chk("track", 32'(track), 32'(e.ckp));
`endif
        $display("cycle %0d rst_n=%0b start=%0b ltsm=%0b ckp=%0h ckn=%0h done=%0b busy=%0b iter=%0d",
                 cycle, rst_n, start, ltsm, ckp, ckn, done, busy, iter_cnt);
      end
    end
  end

  initial begin : driver
    bit s;
    rst_n = 1'b0;
    start = 1'b0;
    ltsm  = 1'b0;
    repeat (3) step(0, 0, 0);
    repeat (2) step(1, 0, 0);
    // full training run, start held high through NORMAL, then released
    step(1, 1, 0);
    repeat (TOTAL + 3) step(1, 1, 0);
    repeat (3) step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    // abort on the second training word
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    repeat (2) step(1, 0, 0);
    // abort on the final training word
    step(1, 1, 0);
    repeat (TOTAL - 1) step(1, 1, 0);
    step(1, 1, 1);
    repeat (2) step(1, 0, 0);
    // reset mid-training with start held: no retrain until a fresh edge
    step(1, 1, 0);
    repeat (2) step(1, 1, 0);
    step(0, 1, 0);
    repeat (4) step(1, 1, 0);
    step(1, 0, 0);
    // fresh run where the start falling edge coincides with completion
    step(1, 1, 0);
    repeat (TOTAL - 1) step(1, 1, 0);
    step(1, 0, 0);
    repeat (3) step(1, 0, 0);
    step(1, 0, 1);
    // randomized traffic
    s = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) s = ~s;
      step(($urandom_range(0, 99) != 0), s, ($urandom_range(0, 39) == 0));
    end
    @(posedge clk);
    #5;
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d queued entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
